// File: rtl/prog_loader_if.sv
// prog_loader_if: bundles the source-byte handshake, program-memory write
// port and status flags of prog_loader.
//   Source side : start, in_valid, in_data[7:0], in_last  -> loader
//                 in_ready                                <- loader
//   Memory side : prog_we, prog_addr, prog_wr[7:0]        <- loader
//   Status      : prog_len, busy, loaded, error           <- loader
// Modports: master = the feeder/consumer environment, slave = the loader.
interface prog_loader_if #(
  parameter int PROG_ADDR_WIDTH = 10
);
  logic                       start;
  logic                       in_valid;
  logic [7:0]                 in_data;
  logic                       in_last;
  logic                       in_ready;
  logic                       prog_we;
  logic [PROG_ADDR_WIDTH-1:0] prog_addr;
  logic [7:0]                 prog_wr;
  logic [PROG_ADDR_WIDTH-1:0] prog_len;
  logic                       busy;
  logic                       loaded;
  logic                       error;

  modport master (
    output start, in_valid, in_data, in_last,
    input  in_ready, prog_we, prog_addr, prog_wr, prog_len, busy, loaded, error
  );

  modport slave (
    input  start, in_valid, in_data, in_last,
    output in_ready, prog_we, prog_addr, prog_wr, prog_len, busy, loaded, error
  );
endinterface

// File: rtl/prog_loader.sv
// prog_loader: streams ASCII program text into a program memory, keeping
// only the eight command characters + - < > . , [ ] and appending a 0x00
// terminator once the final source byte has been seen.
// Ports:
//   clk   - single clock, all state on the rising edge
//   reset - asynchronous, active-high
//   bus   - prog_loader_if.slave (source handshake, memory write port,
//           prog_len and busy/loaded/error status)
// Parameters:
//   PROG_ADDR_WIDTH - program memory address width (last slot is always
//                     kept free for the terminator)
//   DEPTH_WIDTH     - bracket nesting counter width
// Build option:
//   PROG_LOADER_BRACKET_CHECK_EN - when defined, '[' / ']' nesting is
//   validated; unbalanced programs end with error=1 and loaded=0.
module prog_loader #(
  parameter int PROG_ADDR_WIDTH = 10,
  parameter int DEPTH_WIDTH     = 8
) (
  input logic           clk,
  input logic           reset,
  prog_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN, TERM} state_t;

  localparam logic [PROG_ADDR_WIDTH-1:0] PtrMax = '1;

  if (PROG_ADDR_WIDTH < 2) begin : g_addr_width_check
    $error("prog_loader: PROG_ADDR_WIDTH must be at least 2");
  end
  if (DEPTH_WIDTH < 1) begin : g_depth_width_check
    $error("prog_loader: DEPTH_WIDTH must be at least 1");
  end

  state_t                     state;
  logic [PROG_ADDR_WIDTH-1:0] ptr;
  logic                       accept;
  logic                       is_cmd;
  logic                       bracket_err;

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    case (bus.in_data)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
      default:                                                is_cmd = 1'b0;
    endcase
  end

`ifdef PROG_LOADER_BRACKET_CHECK_EN
  localparam logic [DEPTH_WIDTH-1:0] DepthMax = '1;
  logic [DEPTH_WIDTH-1:0] depth;

  // A ']' with nothing open, or a '[' that would wrap the counter, makes the
  // program unusable; both are rejected before anything is written.
  assign bracket_err = (bus.in_data == 8'h5D && depth == '0) ||
                       (bus.in_data == 8'h5B && depth == DepthMax);
`else
  assign bracket_err = 1'b0;
`endif

  // NOTE: every register here is state, so the block uses only non-blocking
  // assignments; mixing in blocking ones would make the result depend on
  // statement order and simulate differently from the synthesised flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      bus.in_ready  <= 1'b0;
      bus.prog_we   <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_wr   <= 8'h00;
      bus.prog_len  <= '0;
      bus.busy      <= 1'b0;
      bus.loaded    <= 1'b0;
      bus.error     <= 1'b0;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
      depth         <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse; any branch issuing a write
      // overrides this default.
      bus.prog_we <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state        <= RECV;
            ptr          <= '0;
            bus.loaded   <= 1'b0;
            bus.error    <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
            depth        <= '0;
`endif
          end
        end

        RECV: begin
          if (accept) begin
            if (is_cmd && (ptr == PtrMax || bracket_err)) begin
              // Rejected command: the load is dead. If this beat was also the
              // last one there is nothing left to drain.
              bus.error <= 1'b1;
              if (bus.in_last) begin
                state        <= IDLE;
                bus.in_ready <= 1'b0;
                bus.busy     <= 1'b0;
              end else begin
                state <= DRAIN;
              end
            end else begin
              if (is_cmd) begin
                bus.prog_we   <= 1'b1;
                bus.prog_addr <= ptr;
                bus.prog_wr   <= bus.in_data;
                ptr           <= ptr + 1'b1;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
                if (bus.in_data == 8'h5B) begin
                  depth <= depth + 1'b1;
                end else if (bus.in_data == 8'h5D) begin
                  depth <= depth - 1'b1;
                end
`endif
              end
              if (bus.in_last) begin
                state        <= TERM;
                bus.in_ready <= 1'b0;
              end
            end
          end
        end

        DRAIN: begin
          if (accept && bus.in_last) begin
            state        <= IDLE;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b0;
          end
        end

        TERM: begin
          bus.prog_we   <= 1'b1;
          bus.prog_addr <= ptr;
          bus.prog_wr   <= 8'h00;
          bus.prog_len  <= ptr;
          bus.busy      <= 1'b0;
          state         <= IDLE;
`ifdef PROG_LOADER_BRACKET_CHECK_EN
          if (depth != '0) begin
            bus.error  <= 1'b1;
            bus.loaded <= 1'b0;
          end else begin
            bus.loaded <= !bus.error;
          end
`else
          bus.loaded <= !bus.error;
`endif
        end

        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader. Two instances: dut_a with
// the default 10-bit address and dut_b with a 3-bit address for the
// overflow case. Expected memory writes are queued as bytes are driven and
// checked by a per-instance monitor whenever prog_we is seen.
module tb_prog_loader;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic clk;
  logic reset;

  prog_loader_if #(.PROG_ADDR_WIDTH(10)) ia ();
  prog_loader_if #(.PROG_ADDR_WIDTH(3))  ib ();

  prog_loader #(.PROG_ADDR_WIDTH(10), .DEPTH_WIDTH(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ia.slave)
  );

  prog_loader #(.PROG_ADDR_WIDTH(3), .DEPTH_WIDTH(8)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ib.slave)
  );

  int  n_checks = 0;
  int  n_fail   = 0;
  int  wr_cnt_a = 0;
  int  wr_cnt_b = 0;
  wr_t qa[$];
  wr_t qb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input int addr, input logic [7:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  // Write monitors: every prog_we pulse must match the oldest queued write.
  always @(negedge clk) begin
    if (ia.prog_we === 1'b1) begin
      wr_cnt_a++;
      n_checks++;
      assert (qa.size() > 0) else begin
        n_fail++;
        $error("FAIL a_wr_unexpected observed addr=0x%0h data=0x%0h expected no write",
               ia.prog_addr, ia.prog_wr);
      end
      if (qa.size() > 0) begin
        wr_t e;
        e = qa.pop_front();
        check("a_wr_addr", 32'(ia.prog_addr), 32'(e.addr));
        check("a_wr_data", 32'(ia.prog_wr), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (ib.prog_we === 1'b1) begin
      wr_cnt_b++;
      n_checks++;
      assert (qb.size() > 0) else begin
        n_fail++;
        $error("FAIL b_wr_unexpected observed addr=0x%0h data=0x%0h expected no write",
               ib.prog_addr, ib.prog_wr);
      end
      if (qb.size() > 0) begin
        wr_t e;
        e = qb.pop_front();
        check("b_wr_addr", 32'(ib.prog_addr), 32'(e.addr));
        check("b_wr_data", 32'(ib.prog_wr), 32'(e.data));
      end
    end
  end

  task automatic pulse_start(input bit sel);
    if (sel) ib.start = 1'b1;
    else     ia.start = 1'b1;
    @(posedge clk); #1;
    ib.start = 1'b0;
    ia.start = 1'b0;
  endtask

  // Drive one beat and hold it until the loader takes it (bounded).
  task automatic send(input bit sel, input logic [7:0] d, input bit last);
    bit done = 1'b0;
    bit rdy;
    if (sel) begin ib.in_valid = 1'b1; ib.in_data = d; ib.in_last = last; end
    else     begin ia.in_valid = 1'b1; ia.in_data = d; ia.in_last = last; end
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      rdy = sel ? ib.in_ready : ia.in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted data=0x%0h", d);
    end
    ia.in_valid = 1'b0; ia.in_last = 1'b0;
    ib.in_valid = 1'b0; ib.in_last = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for busy to drop, then let the monitor drain the queue.
  task automatic wait_idle(input bit sel, input string tag);
    bit b = 1'b1;
    for (int k = 0; k < 20 && b; k++) begin
      @(negedge clk);
      b = sel ? ib.busy : ia.busy;
    end
    check(tag, 32'(b), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_queue_empty(input string tag);
    check(tag, 32'(qa.size() + qb.size()), 32'd0);
  endtask

  initial begin
    ia.start = 1'b0; ia.in_valid = 1'b0; ia.in_data = 8'h00; ia.in_last = 1'b0;
    ib.start = 1'b0; ib.in_valid = 1'b0; ib.in_data = 8'h00; ib.in_last = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_busy",      32'(ia.busy),      32'd0);
    check("rst_in_ready",  32'(ia.in_ready),  32'd0);
    check("rst_prog_we",   32'(ia.prog_we),   32'd0);
    check("rst_loaded",    32'(ia.loaded),    32'd0);
    check("rst_error",     32'(ia.error),     32'd0);
    check("rst_prog_addr", 32'(ia.prog_addr), 32'd0);
    check("rst_prog_wr",   32'(ia.prog_wr),   32'd0);
    check("rst_prog_len",  32'(ia.prog_len),  32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;

    // "++x." -> 2B@0 2B@1 2E@2 00@3
    pulse_start(0);
    check("recv_busy",     32'(ia.busy),     32'd1);
    check("recv_in_ready", 32'(ia.in_ready), 32'd1);
    push(0, 0, 8'h2B); send(0, 8'h2B, 0);
    push(0, 1, 8'h2B); send(0, 8'h2B, 0);
    send(0, 8'h78, 0);
    push(0, 2, 8'h2E); send(0, 8'h2E, 1);
    push(0, 3, 8'h00);
    wait_idle(0, "basic_idle");
    check("basic_len",    32'(ia.prog_len), 32'd3);
    check("basic_loaded", 32'(ia.loaded),   32'd1);
    check("basic_error",  32'(ia.error),    32'd0);
    check_queue_empty("basic_queue");

    // in_valid every other cycle with "+-": two command pulses + terminator
    wr_cnt_a = 0;
    pulse_start(0);
    idle_cycle();
    push(0, 0, 8'h2B); send(0, 8'h2B, 0);
    idle_cycle();
    push(0, 1, 8'h2D); send(0, 8'h2D, 1);
    push(0, 2, 8'h00);
    wait_idle(0, "gap_idle");
    check("gap_we_pulses", 32'(wr_cnt_a),    32'd3);
    check("gap_len",       32'(ia.prog_len), 32'd2);
    check_queue_empty("gap_queue");

    // Empty program: lone non-command with in_last
    pulse_start(0);
    send(0, 8'h61, 1);
    push(0, 0, 8'h00);
    wait_idle(0, "empty_idle");
    check("empty_len",    32'(ia.prog_len), 32'd0);
    check("empty_loaded", 32'(ia.loaded),   32'd1);
    check_queue_empty("empty_queue");

    // start during RECV is ignored
    pulse_start(0);
    push(0, 0, 8'h2B); send(0, 8'h2B, 0);
    push(0, 1, 8'h2D); send(0, 8'h2D, 0);
    pulse_start(0);
    check("restart_busy", 32'(ia.busy), 32'd1);
    push(0, 2, 8'h2E); send(0, 8'h2E, 1);
    push(0, 3, 8'h00);
    wait_idle(0, "restart_idle");
    check("restart_len", 32'(ia.prog_len), 32'd3);
    check_queue_empty("restart_queue");

    // Reset mid-load while a write is on the bus, then reload from 0
    pulse_start(0);
    push(0, 0, 8'h2B); send(0, 8'h2B, 0);
    push(0, 1, 8'h2D); send(0, 8'h2D, 0);
    send(0, 8'h3E, 0);
    reset = 1'b1;
    #1;
    check("midrst_busy",     32'(ia.busy),     32'd0);
    check("midrst_prog_we",  32'(ia.prog_we),  32'd0);
    check("midrst_loaded",   32'(ia.loaded),   32'd0);
    check("midrst_in_ready", 32'(ia.in_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    pulse_start(0);
    push(0, 0, 8'h2E); send(0, 8'h2E, 1);
    push(0, 1, 8'h00);
    wait_idle(0, "reload_idle");
    check("reload_len",    32'(ia.prog_len), 32'd1);
    check("reload_loaded", 32'(ia.loaded),   32'd1);
    check_queue_empty("reload_queue");

    // "[+]" is balanced in either build
    pulse_start(0);
    push(0, 0, 8'h5B); send(0, 8'h5B, 0);
    push(0, 1, 8'h2B); send(0, 8'h2B, 0);
    push(0, 2, 8'h5D); send(0, 8'h5D, 1);
    push(0, 3, 8'h00);
    wait_idle(0, "brk_ok_idle");
    check("brk_ok_loaded", 32'(ia.loaded), 32'd1);
    check("brk_ok_len",    32'(ia.prog_len), 32'd3);
    check_queue_empty("brk_ok_queue");

    // "]+" : unmatched close
    pulse_start(0);
`ifdef PROG_LOADER_BRACKET_CHECK_EN
    send(0, 8'h5D, 0);
    check("brk_close_error",    32'(ia.error),    32'd1);
    check("brk_close_busy",     32'(ia.busy),     32'd1);
    check("brk_close_in_ready", 32'(ia.in_ready), 32'd1);
    send(0, 8'h2B, 1);
    wait_idle(0, "brk_close_idle");
    check("brk_close_loaded", 32'(ia.loaded),   32'd0);
    check("brk_close_len",    32'(ia.prog_len), 32'd3);
`else
    push(0, 0, 8'h5D); send(0, 8'h5D, 0);
    check("brk_close_error", 32'(ia.error), 32'd0);
    check("brk_close_busy",  32'(ia.busy),  32'd1);
    push(0, 1, 8'h2B); send(0, 8'h2B, 1);
    push(0, 2, 8'h00);
    wait_idle(0, "brk_close_idle");
    check("brk_close_loaded", 32'(ia.loaded),   32'd1);
    check("brk_close_len",    32'(ia.prog_len), 32'd2);
`endif
    check_queue_empty("brk_close_queue");

    // "[[+]" : unclosed open; terminator still written
    pulse_start(0);
    push(0, 0, 8'h5B); send(0, 8'h5B, 0);
    push(0, 1, 8'h5B); send(0, 8'h5B, 0);
    push(0, 2, 8'h2B); send(0, 8'h2B, 0);
    push(0, 3, 8'h5D); send(0, 8'h5D, 1);
    push(0, 4, 8'h00);
    wait_idle(0, "brk_open_idle");
    check("brk_open_len", 32'(ia.prog_len), 32'd4);
`ifdef PROG_LOADER_BRACKET_CHECK_EN
    check("brk_open_error",  32'(ia.error),  32'd1);
    check("brk_open_loaded", 32'(ia.loaded), 32'd0);
`else
    check("brk_open_error",  32'(ia.error),  32'd0);
    check("brk_open_loaded", 32'(ia.loaded), 32'd1);
`endif
    check_queue_empty("brk_open_queue");

    // Overflow on the 3-bit instance: slots 0..6 written, 8th '+' rejected
    pulse_start(1);
    for (int i = 0; i < 7; i++) begin
      push(1, i, 8'h2B);
      send(1, 8'h2B, 0);
    end
    check("ovf_error_before", 32'(ib.error), 32'd0);
    send(1, 8'h2B, 0);
    check("ovf_error",    32'(ib.error),    32'd1);
    check("ovf_busy",     32'(ib.busy),     32'd1);
    check("ovf_in_ready", 32'(ib.in_ready), 32'd1);
    send(1, 8'h2D, 0);
    send(1, 8'h78, 1);
    wait_idle(1, "ovf_idle");
    check("ovf_loaded",    32'(ib.loaded),   32'd0);
    check("ovf_error_end", 32'(ib.error),    32'd1);
    check("ovf_len",       32'(ib.prog_len), 32'd0);
    check("ovf_we_pulses", 32'(wr_cnt_b),    32'd7);
    check_queue_empty("ovf_queue");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter PROG_ADDR_WIDTH, default 10, program memory address width.
REQ-002 SHALL have parameter DEPTH_WIDTH, default 8, bracket nesting counter width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  pulse; begin a new program load.
REQ-006 SHALL have port in_valid  input  1  source byte valid.
REQ-007 SHALL have port in_data  input  8  source byte (ASCII program text).
REQ-008 SHALL have port in_last  input  1  marks final source byte; qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  loader accepts byte this cycle.
REQ-010 SHALL have port prog_we  output  1  program memory write strobe.
REQ-011 SHALL have port prog_addr  output  PROG_ADDR_WIDTH  program memory write address.
REQ-012 SHALL have port prog_wr  output  8  program memory write data.
REQ-013 SHALL have port prog_len  output  PROG_ADDR_WIDTH  committed command count, excluding terminator.
REQ-014 SHALL have port busy, loaded, error  output  1 each  status flags.

Function
REQ-015 SHALL implement states IDLE, RECV, DRAIN, TERM.
REQ-016 IDLE: in_ready=0; start -> RECV, clear write pointer, depth, loaded, error; start ignored in any other state.
REQ-017 RECV: in_ready=1; beat accepted when in_valid && in_ready.
REQ-018 Accepted byte in command set {2B,2D,3C,3E,2E,2C,5B,5D} SHALL be written: next cycle prog_we=1, prog_addr=write pointer, prog_wr=byte; pointer +1.
REQ-019 Accepted byte outside command set SHALL be discarded; no write, pointer unchanged.
REQ-020 Accepted beat with in_last=1 (command or not) SHALL move RECV -> TERM.
REQ-021 TERM (one cycle): write 0x00 at write pointer, prog_len<=pointer, loaded<=!error, -> IDLE.
REQ-022 Overflow: command accepted while pointer == 2^PROG_ADDR_WIDTH-1 SHALL not be written, SHALL set error, -> DRAIN (terminator slot always reserved).
REQ-023 DRAIN: in_ready=1, beats consumed without writes; beat with in_last -> IDLE, loaded stays 0, no terminator written.
REQ-024 prog_we SHALL be high exactly one cycle per written command and for the terminator, else 0.
REQ-025 busy SHALL be 1 in RECV, DRAIN, TERM; 0 in IDLE.
REQ-026 Empty program (first accepted beat non-command with in_last) SHALL write 0x00 at 0, prog_len=0, loaded=1.
REQ-027 error and loaded SHALL hold until next start or reset.

Reset
REQ-028 reset SHALL force IDLE immediately; in_ready, prog_we, busy, loaded, error =0; prog_addr, prog_wr, prog_len, pointer, depth =0.
REQ-029 reset mid-load SHALL abandon load; program memory contents undefined, loaded=0.

Configuration
REQ-030 Macro PROG_LOADER_BRACKET_CHECK_EN SHALL enable bracket validation.
REQ-031 With it: '[' depth+1, ']' depth-1; ']' at depth 0 or '[' at depth max SHALL set error, -> DRAIN (byte not written); depth!=0 in TERM SHALL set error, terminator still written, loaded=0.
REQ-032 Without it: no depth counter; brackets written as ordinary commands; error only from overflow.

Verification
REQ-033 start; bytes "++x." last on '.' -> writes 2B@0,2B@1,2E@2,00@3; prog_len=3, loaded=1, error=0.
REQ-034 in_valid toggled every other cycle with "+-" -> exactly two command writes, one prog_we pulse each, then terminator.
REQ-035 PROG_ADDR_WIDTH=3, eight '+' bytes -> writes @0..6, 8th sets error, DRAIN until in_last, loaded=0, no 00 written.
REQ-036 With PROG_LOADER_BRACKET_CHECK_EN: "[+]" -> loaded=1; "]" -> error, DRAIN; "[[+]" -> 00@4, error=1, loaded=0.
REQ-037 reset asserted after 2 commands accepted -> same cycle busy=0, prog_we=0, loaded=0; later start reloads from address 0.
REQ-038 start asserted during RECV -> ignored, pointer and written data unchanged.
